// File: rtl/queue_ctrl_2x123_pkg.sv
// Shared sizing constants and payload/pointer/count types for the 2 x 123-bit
// queue controller and its interface.
package queue_ctrl_pkg;

  localparam int QC_WIDTH = 123;
  localparam int QC_DEPTH = 2;
  localparam int QC_AW    = $clog2(QC_DEPTH);
  localparam int QC_CW    = $clog2(QC_DEPTH + 1);

  typedef logic [QC_WIDTH-1:0] qc_entry_t;
  typedef logic [QC_AW-1:0]    qc_ptr_t;
  typedef logic [QC_CW-1:0]    qc_count_t;

endpackage

// File: rtl/queue_ctrl_2x123_if.sv
// Producer/consumer handshake plus RAM W0/R0 port bundle for queue_ctrl_2x123.
// slave = controller view, master = environment view (producer, consumer, RAM).
interface queue_ctrl_2x123_if
  import queue_ctrl_pkg::*;
();

  logic      enq_valid;
  logic      enq_ready;
  qc_entry_t enq_bits;
  logic      deq_valid;
  logic      deq_ready;
  qc_entry_t deq_bits;
  qc_count_t count;
  qc_ptr_t   mem_W0_addr;
  logic      mem_W0_en;
  qc_entry_t mem_W0_data;
  qc_ptr_t   mem_R0_addr;
  logic      mem_R0_en;
  qc_entry_t mem_R0_data;

  modport slave (
    input  enq_valid, enq_bits, deq_ready, mem_R0_data,
    output enq_ready, deq_valid, deq_bits, count,
           mem_W0_addr, mem_W0_en, mem_W0_data, mem_R0_addr, mem_R0_en
  );

  modport master (
    output enq_valid, enq_bits, deq_ready, mem_R0_data,
    input  enq_ready, deq_valid, deq_bits, count,
           mem_W0_addr, mem_W0_en, mem_W0_data, mem_R0_addr, mem_R0_en
  );

endinterface

// File: rtl/queue_ctrl_2x123_wrap_ptr.sv
// AW-bit wrapping pointer: advances by one on i_inc, cleared asynchronously.
module queue_wrap_ptr #(
  parameter int AW = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          i_inc,
  output logic [AW-1:0] o_ptr
);

  logic [AW-1:0] r_ptr;

  // DEPTH is a power of two, so natural overflow is the wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + AW'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/queue_ctrl_2x123.sv
// Ready/valid FIFO controller driving an external DEPTH x WIDTH RAM (W0 write, R0 comb read).
// Optional macro QUEUE_CTRL_FLOW_EN: empty-queue pass-through from enq to deq in the same cycle.
module queue_ctrl_2x123
  import queue_ctrl_pkg::*;
#(
  parameter int WIDTH = QC_WIDTH,
  parameter int DEPTH = QC_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  queue_ctrl_2x123_if.slave io
);

  logic [AW-1:0]    w_enq_ptr;
  logic [AW-1:0]    w_deq_ptr;
  logic [AW-1:0]    w_ptr_diff;
  logic             r_maybe_full;
  logic             w_ptr_match;
  logic             w_empty;
  logic             w_full;
  logic             w_enq_ready;
  logic             w_deq_valid;
  logic [WIDTH-1:0] w_deq_bits;
  logic             w_do_enq;
  logic             w_do_deq;
  logic             w_pass;
  logic             w_enq_inc;
  logic             w_deq_inc;

  assign w_ptr_match = (w_enq_ptr == w_deq_ptr);
  assign w_empty     = w_ptr_match & ~r_maybe_full;
  assign w_full      = w_ptr_match &  r_maybe_full;
  assign w_enq_ready = ~w_full;

  // reset_n gates the write so the RAM sees no commit while held in reset.
  assign w_do_enq = io.enq_valid & w_enq_ready & reset_n;

`ifdef QUEUE_CTRL_FLOW_EN
  assign w_deq_valid = w_empty ? io.enq_valid : 1'b1;
  assign w_deq_bits  = w_empty ? io.enq_bits  : io.mem_R0_data;
  assign w_pass      = w_empty & w_do_enq & io.deq_ready;
`else
  assign w_deq_valid = ~w_empty;
  assign w_deq_bits  = io.mem_R0_data;
  assign w_pass      = 1'b0;
`endif

  assign w_do_deq = w_deq_valid & io.deq_ready;

  // A pass-through entry never touches the RAM or the pointers.
  assign w_enq_inc = w_do_enq & ~w_pass;
  assign w_deq_inc = w_do_deq & ~w_pass;

  queue_wrap_ptr #(.AW(AW)) u_enq_ptr (
    .clock   (clock),
    .reset_n (reset_n),
    .i_inc   (w_enq_inc),
    .o_ptr   (w_enq_ptr)
  );

  queue_wrap_ptr #(.AW(AW)) u_deq_ptr (
    .clock   (clock),
    .reset_n (reset_n),
    .i_inc   (w_deq_inc),
    .o_ptr   (w_deq_ptr)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_maybe_full <= 1'b0;
    end else if (w_enq_inc != w_deq_inc) begin
      r_maybe_full <= w_enq_inc;
    end
  end

  assign w_ptr_diff = w_enq_ptr - w_deq_ptr;

  assign io.enq_ready   = w_enq_ready;
  assign io.deq_valid   = w_deq_valid;
  assign io.deq_bits    = w_deq_bits;
  assign io.count       = w_full ? CW'(DEPTH) : CW'(w_ptr_diff);
  assign io.mem_W0_en   = w_enq_inc;
  assign io.mem_W0_addr = w_enq_ptr;
  assign io.mem_W0_data = io.enq_bits;
  assign io.mem_R0_en   = ~w_empty;
  assign io.mem_R0_addr = w_deq_ptr;

endmodule

// File: doc/queue_ctrl_2x123.md
Name: queue_ctrl_2x123

Overview:
- Ready/valid FIFO controller that acts as the initiator for the 2-entry x 123-bit dual-port RAM macro (single write port W0, single combinational-read port R0).
- Owns the enqueue/dequeue pointers and the full/empty flag.
- Drives the RAM's W0/R0 address, enable and data; returns R0 read data as the dequeue payload.
- Sits between a producer and a consumer pipeline stage. The RAM is instantiated beside it at the parent level; both share `clock`.

Parameters:
- WIDTH, 123: payload width; must match the RAM data width.
- DEPTH, 2: number of entries; power of two, ≥2; must match the RAM depth.
- AW, $clog2(DEPTH): pointer/address width (1 at default).
- CW, $clog2(DEPTH+1): occupancy count width (2 at default).

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enq_valid  in  1  producer has data.
- enq_ready  out  1  controller can accept.
- enq_bits  in  WIDTH  producer payload.
- deq_valid  out  1  head entry available.
- deq_ready  in  1  consumer takes head.
- deq_bits  out  WIDTH  head payload.
- count  out  CW  current occupancy, 0..DEPTH.
- mem_W0_addr  out  AW  RAM write address.
- mem_W0_en  out  1  RAM write enable.
- mem_W0_data  out  WIDTH  RAM write data.
- mem_R0_addr  out  AW  RAM read address.
- mem_R0_en  out  1  RAM read enable.
- mem_R0_data  in  WIDTH  RAM combinational read data.

Behaviour:
- State: enq_ptr[AW], deq_ptr[AW], maybe_full. All are cleared asynchronously when reset_n=0.
- Derived flags: ptr_match = (enq_ptr==deq_ptr); empty = ptr_match & ~maybe_full; full = ptr_match & maybe_full.
- Outputs (combinational from state): enq_ready = ~full; deq_valid = ~empty.
- Reset values: enq_ready=1, deq_valid=0, count=0, mem_W0_en=0, mem_R0_en=0.
- Handshake: do_enq = enq_valid & enq_ready; do_deq = deq_valid & deq_ready. Valid may not depend on ready on either side.
- Write port: mem_W0_en = do_enq, mem_W0_addr = enq_ptr, mem_W0_data = enq_bits. The RAM commits the entry at the same rising edge the pointer advances.
- Read port: mem_R0_addr = deq_ptr, mem_R0_en = ~empty, deq_bits = mem_R0_data. deq_bits is don't-care (X from the RAM) while deq_valid=0; the bench must not check it then.
- Latency: an entry written at edge N is visible on deq_bits after edge N (one-cycle enq-to-deq minimum). There is no bypass without the optional feature.
- Pointers: each increments by 1 on its fire and wraps modulo DEPTH (natural AW-bit overflow, since DEPTH is a power of two).
- maybe_full: when do_enq != do_deq, maybe_full <= do_enq; otherwise it holds.
- count = full ? DEPTH : (enq_ptr - deq_ptr) mod DEPTH, zero-extended to CW.
- Simultaneous enq+deq:
  - Non-empty, non-full: both pointers advance and count is unchanged.
  - Full: enq_ready=0, so only the dequeue fires; no same-cycle refill.
  - Empty: only the enqueue fires.
- Reset mid-operation: contents are abandoned and the RAM is not cleared. The queue reads empty on the first cycle after reset, and no write is issued while reset_n=0.

Optional Feature:
- Macro: QUEUE_CTRL_FLOW_EN.
- Defined, and only while empty:
  - deq_valid = enq_valid and deq_bits = enq_bits.
  - If deq_ready=1 in that cycle, the entry passes straight through: mem_W0_en=0, pointers and count are unchanged.
  - If deq_ready=0, the entry is written normally.
  - enq_ready is unchanged (still ~full).
- Undefined: behaviour exactly as above, with minimum one-cycle latency.

Decomposition:
- Package queue_ctrl_pkg holds:
  - Constants QC_WIDTH=123, QC_DEPTH=2, QC_AW, QC_CW.
  - Typedefs qc_entry_t (logic[QC_WIDTH-1:0]), qc_ptr_t (logic[QC_AW-1:0]), qc_count_t (logic[QC_CW-1:0]).
- One natural sub-module: queue_wrap_ptr. It is an AW-bit wrapping counter with inc input and async active-low clear, instantiated twice (enq, deq).

Test Plan:
- Reset check: reset_n=0 for 3 cycles, release -> enq_ready=1, deq_valid=0, count=0, mem_W0_en=0 every cycle.
- Fill:
  - Enq 123'h1AA, then 123'h2BB with deq_ready=0 -> count 1, then 2.
  - enq_ready=0 after the second edge.
  - W0 addresses 0, then 1.
  - A third enq_valid is held and not written (mem_W0_en=0).
- Drain in order from the full state: deq_ready=1 for 2 cycles -> deq_bits 1AA, then 2BB; count 1, then 0; deq_valid=0 afterwards.
- Wrap with simultaneous ops:
  - Hold count=1, then enq and deq every cycle for 6 cycles with payload k=1..6.
  - Required: count stays 1, pointers wrap 0→1→0, dequeued data equals the enqueued data one cycle later.
- Full simultaneous: at count=2, assert enq_valid and deq_ready together -> only deq fires, count=1, no write.
- Flow, QUEUE_CTRL_FLOW_EN defined:
  - Empty queue, enq_valid=deq_ready=1, bits 123'h5 -> deq_valid=1 and deq_bits=5 in the same cycle, mem_W0_en=0, count stays 0.
  - Same stimulus with the macro undefined -> deq_valid=0 that cycle, and the entry appears the next cycle.
